// File: rtl/shift_seq_pkg.sv
// Shared encodings for the shifter command sequencer.
// Op codes, shifter priority selects and FSM states.
package shift_seq_pkg;

  localparam logic [1:0] OP_LOAD     = 2'b00;
  localparam logic [1:0] OP_SHR      = 2'b01;
  localparam logic [1:0] OP_SHL      = 2'b10;
  localparam logic [1:0] OP_LOAD_SHR = 2'b11;

  localparam logic [2:0] PRI_LD = 3'b000;
  localparam logic [2:0] PRI_SR = 3'b010;
  localparam logic [2:0] PRI_SL = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic op_has_load(input logic [1:0] op);
    return (op == OP_LOAD) || (op == OP_LOAD_SHR);
  endfunction

endpackage

// File: rtl/shift_seq_ctrl.sv
// Command sequencer driving the shifter's control and data pins.
// One command at a time: optional load, N shift strobes, done pulse.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_fill,
  output logic [WIDTH-1:0] D,
  output logic             D_sr,
  output logic             D_sl,
  output logic             ld,
  output logic             sr,
  output logic             sl,
  output logic [2:0]       prior_con,
  output logic             busy,
  output logic             done
);

  state_e           state_q;
  logic [1:0]       op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] count_q;
  logic             fill_q;
  logic [WIDTH-1:0] d_q;
  logic             dsr_q;
  logic             dsl_q;
  logic             ld_q;
  logic             sr_q;
  logic             sl_q;
  logic [2:0]       pri_q;
  logic             busy_q;
  logic             done_q;

  assign cmd_ready = (state_q == ST_IDLE);

  assign D         = d_q;
  assign D_sr      = dsr_q;
  assign D_sl      = dsl_q;
  assign ld        = ld_q;
  assign sr        = sr_q;
  assign sl        = sl_q;
  assign prior_con = pri_q;
  assign busy      = busy_q;
  assign done      = done_q;

  // Outputs are set on the edge entering a state, so each
  // strobe is high for exactly the cycles spent in that state.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= ST_IDLE;
      op_q    <= OP_LOAD;
      cnt_q   <= '0;
      count_q <= '0;
      fill_q  <= 1'b0;
      d_q     <= '0;
      dsr_q   <= 1'b0;
      dsl_q   <= 1'b0;
      ld_q    <= 1'b0;
      sr_q    <= 1'b0;
      sl_q    <= 1'b0;
      pri_q   <= PRI_LD;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q   <= cmd_op;
            cnt_q  <= cmd_cnt;
            fill_q <= cmd_fill;
            busy_q <= 1'b1;
            if (op_has_load(cmd_op)) begin
              state_q <= ST_LOAD;
              ld_q    <= 1'b1;
              pri_q   <= PRI_LD;
              d_q     <= cmd_data;
            end else if (cmd_cnt != '0) begin
              state_q <= ST_SHIFT;
              count_q <= cmd_cnt;
              if (cmd_op == OP_SHL) begin
                sl_q  <= 1'b1;
                pri_q <= PRI_SL;
                dsl_q <= cmd_fill;
              end else begin
                sr_q  <= 1'b1;
                pri_q <= PRI_SR;
                dsr_q <= cmd_fill;
              end
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          ld_q <= 1'b0;
          if (op_q == OP_LOAD_SHR && cnt_q != '0) begin
            state_q <= ST_SHIFT;
            count_q <= cnt_q;
            sr_q    <= 1'b1;
            pri_q   <= PRI_SR;
            dsr_q   <= fill_q;
          end else begin
            state_q <= ST_DONE;
            pri_q   <= PRI_LD;
            done_q  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          count_q <= count_q - 1'b1;
          if (count_q == CNT_W'(1)) begin
            state_q <= ST_DONE;
            sr_q    <= 1'b0;
            sl_q    <= 1'b0;
            pri_q   <= PRI_LD;
            done_q  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl driving a behavioural shifter.
// Vector table, directed corner sequences and random commands.
module tb_shift_seq_ctrl;
  import shift_seq_pkg::*;

  localparam int W  = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          clr;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [CW-1:0] cmd_cnt;
  logic [W-1:0]  cmd_data;
  logic          cmd_fill;
  logic [W-1:0]  D;
  logic          D_sr, D_sl, ld, sr, sl;
  logic [2:0]    prior_con;
  logic          busy, done;

  always #5 clk = ~clk;

  shift_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .clr(clr),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_cnt(cmd_cnt),
    .cmd_data(cmd_data), .cmd_fill(cmd_fill),
    .D(D), .D_sr(D_sr), .D_sl(D_sl),
    .ld(ld), .sr(sr), .sl(sl),
    .prior_con(prior_con), .busy(busy), .done(done)
  );

  // Shifter downstream of the sequencer: right shift fills MSB, left fills LSB.
  logic [W-1:0] q_sh;
  always_ff @(posedge clk or negedge clr) begin
    if (!clr)    q_sh <= '0;
    else if (ld) q_sh <= D;
    else if (sr) q_sh <= {D_sr, q_sh[W-1:1]};
    else if (sl) q_sh <= {q_sh[W-2:0], D_sl};
  end

  int total  = 0;
  int passed = 0;

  logic [W-1:0] exp_d, exp_q;
  logic         exp_dsr, exp_dsl;

  typedef struct {
    logic [1:0]    op;
    logic [CW-1:0] cnt;
    logic [W-1:0]  data;
    logic          fill;
    logic [W-1:0]  q;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [14:0] outs();
    return {cmd_ready, busy, done, ld, sr, sl, prior_con,
            D, D_sr, D_sl};
  endfunction

  task automatic scramble();
    cmd_op   = 2'($urandom);
    cmd_cnt  = CW'($urandom);
    cmd_data = W'($urandom);
    cmd_fill = 1'($urandom);
  endtask

  // Called at a negedge while idle; returns at the negedge of the
  // idle cycle after done. keep leaves cmd_valid high (next call follows).
  task automatic run_cmd(input logic [1:0] op, input logic [CW-1:0] cnt,
                         input logic [W-1:0] data, input logic fill,
                         input bit keep);
    int k, nl, ns;
    bit is_ld, is_sh, is_dn, left;
    logic [2:0] pri;
    cmd_op = op; cmd_cnt = cnt; cmd_data = data; cmd_fill = fill;
    cmd_valid = 1'b1;
    k = 0;
    while (!cmd_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("accept_ready", {31'd0, cmd_ready}, 32'd1);
    if (!cmd_ready) begin
      cmd_valid = 1'b0;
      return;
    end
    nl   = op_has_load(op) ? 1 : 0;
    ns   = (op == OP_LOAD) ? 0 : int'(cnt);
    left = (op == OP_SHL);
    @(negedge clk);
    for (int i = 0; i < nl + ns + 1; i++) begin
      if (keep) scramble();
      else cmd_valid = 1'b0;
      is_ld = (i < nl);
      is_sh = (i >= nl) && (i < nl + ns);
      is_dn = (i == nl + ns);
      if (is_ld) exp_d = data;
      if (is_sh && !left) exp_dsr = fill;
      if (is_sh && left) exp_dsl = fill;
      pri = is_sh ? (left ? PRI_SL : PRI_SR) : PRI_LD;
      chk($sformatf("cyc%0d_op%0d_outs", i, op), {17'd0, outs()},
          {17'd0, 1'b0, 1'b1, is_dn, is_ld, is_sh && !left,
           is_sh && left, pri, exp_d, exp_dsr, exp_dsl});
      chk($sformatf("cyc%0d_q", i), {28'd0, q_sh}, {28'd0, exp_q});
      if (is_ld) exp_q = data;
      else if (is_sh && left) exp_q = W'(int'(exp_q) * 2 + int'(fill));
      else if (is_sh) exp_q = W'(int'(exp_q) / 2 + (fill ? 2**(W-1) : 0));
      @(negedge clk);
    end
    chk("idle_outs", {17'd0, outs()},
        {17'd0, 6'b100000, PRI_LD, exp_d, exp_dsr, exp_dsl});
    chk("idle_q", {28'd0, q_sh}, {28'd0, exp_q});
  endtask

  initial begin
    tbl[0] = '{OP_LOAD,     3'd5, 4'b0110, 1'b0, 4'b0110};
    tbl[1] = '{OP_SHL,      3'd3, 4'b0000, 1'b1, 4'b0111};
    tbl[2] = '{OP_SHR,      3'd0, 4'b1111, 1'b1, 4'b0111};
    tbl[3] = '{OP_LOAD_SHR, 3'd2, 4'b0110, 1'b1, 4'b1101};
    tbl[4] = '{OP_LOAD_SHR, 3'd1, 4'b1001, 1'b0, 4'b0100};
    tbl[5] = '{OP_SHL,      3'd1, 4'b0000, 1'b0, 4'b1000};
    tbl[6] = '{OP_SHR,      3'd7, 4'b0000, 1'b1, 4'b1111};
    tbl[7] = '{OP_LOAD_SHR, 3'd0, 4'b0011, 1'b1, 4'b0011};

    clr = 1'b0; cmd_valid = 1'b0;
    cmd_op = OP_LOAD; cmd_cnt = '0; cmd_data = '0; cmd_fill = 1'b0;
    exp_d = '0; exp_q = '0; exp_dsr = 1'b0; exp_dsl = 1'b0;
    #12;
    chk("reset_outs", {17'd0, outs()}, {17'd0, 15'b100000_000_0000_00});
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);

    foreach (tbl[n]) begin
      run_cmd(tbl[n].op, tbl[n].cnt, tbl[n].data, tbl[n].fill, 1'b0);
      chk($sformatf("table%0d_q", n), {28'd0, q_sh}, {28'd0, tbl[n].q});
    end

    // Held-off valid during a max-count LOAD_SHR, then a real command.
    run_cmd(OP_LOAD_SHR, 3'd7, 4'b0101, 1'b0, 1'b1);
    run_cmd(OP_SHL, 3'd2, 4'b1100, 1'b1, 1'b0);
    chk("holdoff_q", {28'd0, q_sh}, {28'd0, 4'b0011});

    // Back-to-back loads with valid held.
    run_cmd(OP_LOAD, 3'd0, 4'b1010, 1'b0, 1'b1);
    run_cmd(OP_LOAD, 3'd3, 4'b0101, 1'b0, 1'b0);
    chk("b2b_q", {28'd0, q_sh}, {28'd0, 4'b0101});

    // Reset in the middle of a shift run.
    cmd_op = OP_LOAD_SHR; cmd_cnt = 3'd7; cmd_data = 4'b1010;
    cmd_fill = 1'b1; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrun_sr", {31'd0, sr}, 32'd1);
    #2 clr = 1'b0;
    #1;
    chk("async_reset_outs", {17'd0, outs()},
        {17'd0, 15'b100000_000_0000_00});
    cmd_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("in_reset_outs", {17'd0, outs()},
          {17'd0, 15'b100000_000_0000_00});
    end
    cmd_valid = 1'b0;
    clr = 1'b1;
    exp_d = '0; exp_q = '0; exp_dsr = 1'b0; exp_dsl = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_reset_outs", {17'd0, outs()},
          {17'd0, 15'b100000_000_0000_00});
    end

    for (int n = 0; n < 30; n++) begin
      run_cmd(2'($urandom), CW'($urandom), W'($urandom), 1'($urandom),
              (n < 29) ? 1'($urandom) : 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
